// File: rtl/dispense_order_sequencer.sv
// dispense_order_sequencer: accepts one snack order and steps through the slots
// in order, one start_dispense/busy handshake per nonzero slot, then reports
// completion or error (ack/run timeout, abort) upstream.
module dispense_order_sequencer #(
  parameter int unsigned N_SLOTS         = 4,
  parameter int unsigned ACK_TIMEOUT_CYC = 1024,
  parameter int unsigned RUN_TIMEOUT_CYC = 600000000,
  localparam int unsigned SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1,
  localparam int unsigned CNT_W  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       order_valid_i,
  output logic                       order_ready_o,
  input  logic [CNT_W*N_SLOTS-1:0]   order_counts_i,
  input  logic                       order_abort_i,
  output logic [N_SLOTS-1:0]         start_dispense_o,
  output logic [CNT_W-1:0]           dispense_count_o,
  input  logic [N_SLOTS-1:0]         disp_busy_i,
  output logic [SLOT_W-1:0]          active_slot_o,
  output logic                       busy_o,
  output logic                       order_done_o,
  output logic                       order_error_o,
  output logic [SLOT_W-1:0]          error_slot_o
);

  localparam int unsigned TMR_W = 32;
  // The start pulse cycle counts as the first cycle of the ack window, so the
  // last ACK cycle allowed to decide is two short of the window length.
  localparam logic [TMR_W-1:0] ACK_LIMIT = TMR_W'(ACK_TIMEOUT_CYC - 2);
  localparam logic [TMR_W-1:0] RUN_LIMIT = TMR_W'(RUN_TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_START, S_ACK, S_RUN, S_NEXT, S_DONE, S_ERR
  } state_e;

  state_e                     state_q, state_d;
  logic [CNT_W*N_SLOTS-1:0]   counts_q, counts_d;
  logic [SLOT_W-1:0]          slot_q, slot_d;
  logic [TMR_W-1:0]           timer_q, timer_d;
  logic [N_SLOTS-1:0]         start_q, start_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [SLOT_W-1:0]          err_slot_q, err_slot_d;
  logic                       ready_q, ready_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       error_q, error_d;

  logic [CNT_W-1:0]           slot_cnt [N_SLOTS];
  logic [CNT_W-1:0]           cur_cnt;
  logic                       cur_busy;
  logic                       last_slot;
  logic [N_SLOTS-1:0]         slot_onehot;
  logic [TMR_W-1:0]           timer_inc;
  logic                       ack_expired;
  logic                       run_expired;

  // Split the latched order into per-slot counts.
  for (genvar g = 0; g < N_SLOTS; g++) begin : g_cnt
    assign slot_cnt[g] = counts_q[CNT_W*g +: CNT_W];
  end

  // Per-slot helpers derived from registered state; only the active slot's busy is observed.
  always_comb begin
    cur_cnt     = slot_cnt[slot_q];
    cur_busy    = disp_busy_i[slot_q];
    last_slot   = (slot_q == SLOT_W'(N_SLOTS - 1));
    slot_onehot = N_SLOTS'(1) << slot_q;
    timer_inc   = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);
    ack_expired = (timer_q >= ACK_LIMIT);
    run_expired = (timer_q >= RUN_LIMIT);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    counts_d   = counts_q;
    slot_d     = slot_q;
    timer_d    = timer_q;
    start_d    = '0;
    cnt_d      = '0;
    err_slot_d = err_slot_q;

    unique case (state_q)
      S_IDLE: begin
        if (order_valid_i) begin
          counts_d = order_counts_i;
          slot_d   = '0;
          state_d  = S_SCAN;
        end
      end
      S_SCAN: begin
        if (order_abort_i) begin
          state_d = S_ERR;
        end else if (cur_cnt == '0) begin
          if (last_slot) state_d = S_DONE;
          else           slot_d  = slot_q + SLOT_W'(1);
        end else begin
          state_d = S_START;
          // Issue the pulse on entry when the controller is already free.
          if (!cur_busy) begin
            start_d = slot_onehot;
            cnt_d   = cur_cnt;
          end
        end
      end
      S_START: begin
        timer_d = timer_inc;
        if (order_abort_i) begin
          state_d = S_ERR;
        end else if (start_q != '0) begin
          state_d = S_ACK;
        end else if (run_expired) begin
          state_d = S_ERR;
        end else if (!cur_busy) begin
          start_d = slot_onehot;
          cnt_d   = cur_cnt;
        end
      end
      S_ACK: begin
        timer_d = timer_inc;
        if (order_abort_i)    state_d = S_ERR;
        else if (cur_busy)    state_d = S_RUN;
        else if (ack_expired) state_d = S_ERR;
      end
      S_RUN: begin
        timer_d = timer_inc;
        if (order_abort_i)    state_d = S_ERR;
        else if (!cur_busy)   state_d = S_NEXT;
        else if (run_expired) state_d = S_ERR;
      end
      S_NEXT: begin
        if (order_abort_i) begin
          state_d = S_ERR;
        end else if (last_slot) begin
          state_d = S_DONE;
        end else begin
          slot_d  = slot_q + SLOT_W'(1);
          state_d = S_SCAN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) timer_d = '0;
    if (state_d == S_ERR)   err_slot_d = slot_q;
  end

  // Status flags registered from the next state so they line up with it.
  always_comb begin
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERR);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      counts_q   <= '0;
      slot_q     <= '0;
      timer_q    <= '0;
      start_q    <= '0;
      cnt_q      <= '0;
      err_slot_q <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      counts_q   <= counts_d;
      slot_q     <= slot_d;
      timer_q    <= timer_d;
      start_q    <= start_d;
      cnt_q      <= cnt_d;
      err_slot_q <= err_slot_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign order_ready_o    = ready_q;
  assign start_dispense_o = start_q;
  assign dispense_count_o = cnt_q;
  assign active_slot_o    = slot_q;
  assign busy_o           = busy_q;
  assign order_done_o     = done_q;
  assign order_error_o    = error_q;
  assign error_slot_o     = err_slot_q;

endmodule

// File: tb/tb_dispense_order_sequencer.sv
// Bench for dispense_order_sequencer: dispenser model per slot, event logs of
// pulses/done/error, and a cycle-cost model of an order derived from the handshake rules.
module tb_dispense_order_sequencer;

  localparam int NS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        order_valid;
  logic        order_ready;
  logic [11:0] order_counts;
  logic        order_abort;
  logic [3:0]  start_dispense;
  logic [2:0]  dispense_count;
  logic [3:0]  disp_busy;
  logic [1:0]  active_slot;
  logic        busy;
  logic        order_done;
  logic        order_error;
  logic [1:0]  error_slot;

  dispense_order_sequencer #(
    .N_SLOTS(4), .ACK_TIMEOUT_CYC(16), .RUN_TIMEOUT_CYC(1000)
  ) dut (
    .clk(clk), .rst(rst),
    .order_valid_i(order_valid), .order_ready_o(order_ready),
    .order_counts_i(order_counts), .order_abort_i(order_abort),
    .start_dispense_o(start_dispense), .dispense_count_o(dispense_count),
    .disp_busy_i(disp_busy), .active_slot_o(active_slot),
    .busy_o(busy), .order_done_o(order_done), .order_error_o(order_error),
    .error_slot_o(error_slot)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct { int slot; int cnt; int cyc; } pulse_t;
  typedef struct { int cyc; int slot; } err_t;
  pulse_t plog[$];
  int     done_log[$];
  err_t   elog[$];

  // Dispenser model: busy rises one cycle after the pulse and stays high 30*count cycles.
  logic [3:0] dev_en;
  int rem  [NS];
  int pend [NS];
  int pcnt [NS];

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (pend[i] != 0) begin
        rem[i]  = 30 * pcnt[i];
        pend[i] = 0;
      end else if (rem[i] > 0) begin
        rem[i]--;
      end
      if (start_dispense[i] === 1'b1 && dev_en[i]) begin
        pend[i] = 1;
        pcnt[i] = int'(dispense_count);
      end
      disp_busy[i] = (rem[i] > 0);
    end
  end

  // Event monitor: logs pulses, done and error pulses with their cycle numbers.
  always @(negedge clk) begin
    pulse_t p;
    err_t   e;
    if (rst === 1'b0) begin
      chk("pulse_shape",
          64'($onehot0(start_dispense) && (start_dispense != 4'd0 || dispense_count == 3'd0)), 64'd1);
      if (start_dispense != 4'd0) begin
        p.slot = 0;
        for (int i = 0; i < NS; i++) if (start_dispense[i]) p.slot = i;
        p.cnt = int'(dispense_count);
        p.cyc = cyc;
        plog.push_back(p);
        chk("pulse_active_slot", 64'(active_slot), 64'(p.slot));
      end
      if (order_done === 1'b1) done_log.push_back(cyc);
      if (order_error === 1'b1) begin
        e.cyc  = cyc;
        e.slot = int'(error_slot);
        elog.push_back(e);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ready"},    64'(order_ready),    64'd1);
    chk({nm, "_start"},    64'(start_dispense), 64'd0);
    chk({nm, "_count"},    64'(dispense_count), 64'd0);
    chk({nm, "_active"},   64'(active_slot),    64'd0);
    chk({nm, "_busy"},     64'(busy),           64'd0);
    chk({nm, "_done"},     64'(order_done),     64'd0);
    chk({nm, "_error"},    64'(order_error),    64'd0);
    chk({nm, "_errslot"},  64'(error_slot),     64'd0);
  endtask

  task automatic send_order(input logic [11:0] c, input bit hold, output int t);
    int k = 0;
    while (order_ready !== 1'b1 && k < 2000) begin step(); k++; end
    chk("ready_before_send", 64'(order_ready), 64'd1);
    plog.delete(); done_log.delete(); elog.delete();
    order_counts = c;
    order_valid  = 1'b1;
    t = cyc;
    step();
    if (!hold) begin
      order_valid  = 1'b0;
      order_counts = 12'($urandom);
    end
  endtask

  task automatic wait_end(input int budget);
    int k = 0;
    while (done_log.size() == 0 && elog.size() == 0 && k < budget) begin step(); k++; end
    chk("end_event_seen", 64'(done_log.size() + elog.size()), 64'd1);
  endtask

  task automatic settle();
    int k = 0;
    while (disp_busy != 4'd0 && k < 600) begin step(); k++; end
    step(); step();
    chk("dispensers_idle", 64'(disp_busy), 64'd0);
  endtask

  // Reference: zero slot costs one scan cycle; a nonzero slot costs scan, start,
  // ack, 30*count run cycles and next. Pulse lands one cycle after its scan.
  task automatic check_order(input string nm, input logic [11:0] c, input int t);
    int at  = t + 1;
    int idx = 0;
    for (int s = 0; s < NS; s++) begin
      int n = int'(c[3*s +: 3]);
      if (n != 0) begin
        at += 1;
        if (idx < plog.size()) begin
          chk({nm, "_pulse_slot"}, 64'(plog[idx].slot), 64'(s));
          chk({nm, "_pulse_cnt"},  64'(plog[idx].cnt),  64'(n));
          chk({nm, "_pulse_cyc"},  64'(plog[idx].cyc),  64'(at));
        end
        idx++;
        at += 3 + 30 * n;
      end else begin
        at += 1;
      end
    end
    chk({nm, "_num_pulses"}, 64'(plog.size()),     64'(idx));
    chk({nm, "_num_done"},   64'(done_log.size()), 64'd1);
    chk({nm, "_num_err"},    64'(elog.size()),     64'd0);
    if (done_log.size() > 0) chk({nm, "_done_cyc"}, 64'(done_log[0]), 64'(at));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] c, cb;
    int t, t2, a, d, k;

    rst = 1'b1; order_valid = 1'b0; order_counts = '0; order_abort = 1'b0; dev_en = 4'hF;
    repeat (3) step();
    chk_reset("por");
    rst = 1'b0;
    step();
    chk("idle_ready", 64'(order_ready), 64'd1);

    // Abort in IDLE is ignored.
    order_abort = 1'b1; step(); step(); order_abort = 1'b0; step();
    chk("idle_abort_err",  64'(elog.size()), 64'd0);
    chk("idle_abort_busy", 64'(busy),        64'd0);

    // Mixed order with a skipped slot.
    c = {3'd1, 3'd2, 3'd0, 3'd3};
    send_order(c, 1'b0, t);
    wait_end(2000);
    check_order("t1", c, t);

    // All-zero order: no pulses, done exactly five cycles after acceptance.
    send_order(12'd0, 1'b0, t);
    for (int j = 1; j <= 6; j++) begin
      chk("t2_busy", 64'(busy),       64'(j <= 5));
      chk("t2_done", 64'(order_done), 64'(j == 5));
      step();
    end
    check_order("t2", 12'd0, t);

    // Abort during slot 0 run.
    settle();
    c = 12'o5555;
    send_order(c, 1'b0, t);
    k = 0;
    while (plog.size() == 0 && k < 100) begin step(); k++; end
    chk("t4_first_pulse_cyc", 64'(cyc), 64'(t + 2));
    repeat (10) step();
    order_abort = 1'b1; a = cyc;
    step();
    order_abort = 1'b0;
    chk("t4_error",    64'(order_error), 64'd1);
    chk("t4_err_slot", 64'(error_slot),  64'd0);
    repeat (200) step();
    chk("t4_pulses",  64'(plog.size()),     64'd1);
    chk("t4_done",    64'(done_log.size()), 64'd0);
    chk("t4_nerr",    64'(elog.size()),     64'd1);
    if (elog.size() > 0) chk("t4_err_cyc", 64'(elog[0].cyc), 64'(a + 1));

    // Ack timeout on slot 2.
    settle();
    dev_en = 4'b1011;
    c = {3'd1, 3'd1, 3'd1, 3'd1};
    send_order(c, 1'b0, t);
    wait_end(2000);
    chk("t3_pulses", 64'(plog.size()),     64'd3);
    chk("t3_done",   64'(done_log.size()), 64'd0);
    chk("t3_nerr",   64'(elog.size()),     64'd1);
    for (int j = 0; j < plog.size(); j++) chk("t3_pulse_slot", 64'(plog[j].slot), 64'(j));
    if (elog.size() > 0) begin
      chk("t3_err_cyc",  64'(elog[0].cyc),  64'(t + 2 + 34 + 34 + 16));
      chk("t3_err_slot", 64'(elog[0].slot), 64'd2);
    end
    dev_en = 4'hF;

    // Reset during slot 1 run, then a fresh order.
    settle();
    c = {3'd0, 3'd0, 3'd3, 3'd1};
    send_order(c, 1'b0, t);
    k = 0;
    while (plog.size() < 2 && k < 300) begin step(); k++; end
    repeat (20) step();
    chk("t5_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk_reset("t5");
    step();
    rst = 1'b0;
    step();
    c = {3'd0, 3'd0, 3'd0, 3'd1};
    send_order(c, 1'b0, t);
    wait_end(2000);
    check_order("t5b", c, t);

    // order_valid held high: second order only after the DONE cycle.
    settle();
    c  = {3'd1, 3'd0, 3'd0, 3'd2};
    cb = {3'd0, 3'd0, 3'd1, 3'd1};
    send_order(c, 1'b1, t);
    order_counts = cb;
    k = 0;
    while (done_log.size() == 0 && elog.size() == 0 && k < 2000) begin
      chk("t6_not_ready", 64'(order_ready), 64'd0);
      step(); k++;
    end
    d = cyc;
    check_order("t6a", c, t);
    plog.delete(); done_log.delete();
    step();
    chk("t6_ready_idle", 64'(order_ready), 64'd1);
    step();
    chk("t6_ready_busy", 64'(order_ready), 64'd0);
    chk("t6_busy",       64'(busy),        64'd1);
    order_valid = 1'b0;
    t2 = d + 1;
    wait_end(2000);
    check_order("t6b", cb, t2);

    // Random orders against the cost model.
    for (int r = 0; r < 5; r++) begin
      settle();
      c = 12'($urandom);
      send_order(c, 1'b0, t);
      wait_end(2000);
      check_order("rand", c, t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
